bcd_dspl_fmt: RTL

Formats a 27-bit unsigned binary value into the eight 6-bit display-digit words {enable, hex[3:0], dp} consumed by the Nexys A7 8-digit display driver. Conversion is iterative (shift-and-add-3, one bit per clock). The block adds leading-zero blanking, optional decimal-point placement and an overflow indication. It sits between the application datapath and the display driver; its d1..d8 outputs connect directly to the driver's d1..d8 inputs.

---
 rtl/bcd_dspl_fmt_if.sv | 29 ++
 rtl/bcd_dspl_fmt.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_dspl_fmt_if.sv
// Request/result bundle between the application datapath and bcd_dspl_fmt.
// The master side issues conversions; the slave side (the formatter) returns digit words.
interface bcd_dspl_fmt_if;
    logic        start;
    logic [26:0] value;
    logic        dp_en;
    logic [2:0]  dp_pos;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [5:0]  d1;
    logic [5:0]  d2;
    logic [5:0]  d3;
    logic [5:0]  d4;
    logic [5:0]  d5;
    logic [5:0]  d6;
    logic [5:0]  d7;
    logic [5:0]  d8;

    modport master (
        output start, value, dp_en, dp_pos,
        input  busy, done, ovf, d1, d2, d3, d4, d5, d6, d7, d8
    );

    modport slave (
        input  start, value, dp_en, dp_pos,
        output busy, done, ovf, d1, d2, d3, d4, d5, d6, d7, d8
    );
endinterface

// File: rtl/bcd_dspl_fmt.sv
// Iterative binary-to-BCD formatter for the 8-digit display driver: one shift-and-add-3
// step per clock, then leading-zero blanking, decimal point and overflow 'E' at load.
module bcd_dspl_fmt #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    bcd_dspl_fmt_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [26:0] shift_r, shift_s;
    logic [31:0] bcd_r, bcd_s;
    logic [4:0]  cnt_r, cnt_s;
    logic        dp_en_r, dp_en_s;
    logic [2:0]  dp_pos_r, dp_pos_s;
    logic        big_r, big_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        ovf_r, ovf_s;
    logic [5:0]  dig_r [8];
    logic [5:0]  dig_s [8];
    logic [5:0]  fmt_s [8];

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
    function automatic logic [31:0] dd_step(input logic [31:0] b, input logic in_bit);
        logic [31:0] a;
        a = b;
        for (int i = 0; i < 8; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                a[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                a[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return {a[30:0], in_bit};
    endfunction

    // Digit words derived from the finished BCD register; scanned from d8 down so a
    // nonzero nibble keeps every less significant digit lit.
    always_comb begin
        logic nz_v;
        logic en_v;
        logic dp_v;
        nz_v = 1'b0;
        en_v = 1'b0;
        dp_v = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            nz_v = nz_v | (bcd_r[k*4 +: 4] != 4'd0);
            en_v = (k == 32'sd0) | ~BLANK_LZ | nz_v | (dp_en_r & (k[2:0] <= dp_pos_r));
            dp_v = dp_en_r & (k[2:0] == dp_pos_r);
            if (big_r) begin
                fmt_s[k] = (k == 32'sd7) ? 6'b111100 : 6'b000000;
            end else if (en_v) begin
                fmt_s[k] = {1'b1, bcd_r[k*4 +: 4], dp_v};
            end else begin
                fmt_s[k] = 6'b000000;
            end
        end
    end

    // Next-state and next-register values for the IDLE -> CONV -> LOAD sequence.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        bcd_s    = bcd_r;
        cnt_s    = cnt_r;
        dp_en_s  = dp_en_r;
        dp_pos_s = dp_pos_r;
        big_s    = big_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        ovf_s    = ovf_r;
        dig_s    = dig_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    shift_s  = bus.value;
                    dp_en_s  = bus.dp_en;
                    dp_pos_s = bus.dp_pos;
                    big_s    = (bus.value > 27'd99_999_999);
                    bcd_s    = 32'd0;
                    cnt_s    = 5'd0;
                    busy_s   = 1'b1;
                    state_s  = CONV;
                end else begin
                    state_s  = IDLE;
                end
            end
            CONV: begin
                bcd_s   = dd_step(bcd_r, shift_r[26]);
                shift_s = {shift_r[25:0], 1'b0};
                cnt_s   = cnt_r + 5'd1;
                if (cnt_r == 5'd26) begin
                    state_s = LOAD;
                end else begin
                    state_s = CONV;
                end
            end
            LOAD: begin
                dig_s   = fmt_s;
                ovf_s   = big_r;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset darkens the display and aborts any conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shift_r  <= 27'd0;
            bcd_r    <= 32'd0;
            cnt_r    <= 5'd0;
            dp_en_r  <= 1'b0;
            dp_pos_r <= 3'd0;
            big_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            dig_r    <= '{default: 6'b000000};
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            bcd_r    <= bcd_s;
            cnt_r    <= cnt_s;
            dp_en_r  <= dp_en_s;
            dp_pos_r <= dp_pos_s;
            big_r    <= big_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            ovf_r    <= ovf_s;
            dig_r    <= dig_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;
    assign bus.d1   = dig_r[0];
    assign bus.d2   = dig_r[1];
    assign bus.d3   = dig_r[2];
    assign bus.d4   = dig_r[3];
    assign bus.d5   = dig_r[4];
    assign bus.d6   = dig_r[5];
    assign bus.d7   = dig_r[6];
    assign bus.d8   = dig_r[7];

endmodule
